// File: rtl/fp_attendance_ctrl.sv
// fp_attendance_ctrl: parses A5/CMD/ID/CHK UART frames, runs enrol/verify/clear on an ID table with attendance flags, reports one result per frame
module fp_attendance_ctrl #(
  parameter int DEPTH = 8,
  parameter logic [7:0] SOF = 8'hA5,
  parameter int TIMEOUT_CLKS = 104140,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          o_Busy,
  output logic          o_Result_DV,
  output logic [2:0]    o_Result,
  output logic [7:0]    o_Result_Id,
  output logic [IW-1:0] o_Result_Slot,
  output logic [IW:0]   o_Enrolled,
  output logic [IW:0]   o_Attend_Count
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CLKS - 1);
  localparam logic [2:0] R_ENR = 3'd0, R_MATCH = 3'd1, R_NOMATCH = 3'd2, R_FULL = 3'd3,
                         R_DUP = 3'd4, R_BAD = 3'd5, R_CLR = 3'd6, R_TOUT = 3'd7;
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ID, GET_CHK, SEARCH, DECIDE, CLEAR, REPORT} state_t;
  state_t state, state_nxt;
  logic [7:0] cmd, id;
  logic [7:0] ids [DEPTH];
  logic [DEPTH-1:0] valid, present;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx, match_slot, free_slot;
  logic match_hit, free_hit;
  logic [2:0] rpt_code;
  logic in_get, timed_out, frame_ok;
  assign in_get = state == GET_CMD || state == GET_ID || state == GET_CHK;
  assign timed_out = in_get && !i_Rx_DV && timer == TLIM;
  assign frame_ok = i_Rx_Byte == (cmd ^ id) &&
                    (cmd == 8'h03 || ((cmd == 8'h01 || cmd == 8'h02) && id != 8'h00));
  assign o_Busy = !(state == IDLE || in_get);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = i_Rx_DV && i_Rx_Byte == SOF ? GET_CMD : IDLE;
      GET_CMD: state_nxt = i_Rx_DV ? GET_ID : timed_out ? REPORT : GET_CMD;
      GET_ID:  state_nxt = i_Rx_DV ? GET_CHK : timed_out ? REPORT : GET_ID;
      GET_CHK: state_nxt = !i_Rx_DV ? (timed_out ? REPORT : GET_CHK) :
                           !frame_ok ? REPORT : cmd == 8'h03 ? CLEAR : SEARCH;
      SEARCH:  state_nxt = idx == LAST ? DECIDE : SEARCH;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      cmd <= '0;
      id <= '0;
      timer <= '0;
      idx <= '0;
      match_hit <= 1'b0;
      free_hit <= 1'b0;
      match_slot <= '0;
      free_slot <= '0;
      rpt_code <= '0;
      valid <= '0;
      present <= '0;
      for (int i = 0; i < DEPTH; i++) ids[i] <= '0;
      o_Result_DV <= 1'b0;
      o_Result <= '0;
      o_Result_Id <= '0;
      o_Result_Slot <= '0;
      o_Enrolled <= '0;
      o_Attend_Count <= '0;
    end else begin
      o_Result_DV <= 1'b0;
      timer <= in_get && !i_Rx_DV ? timer + 1'b1 : '0;
      if (timed_out) begin
        rpt_code <= R_TOUT;
        id <= '0;
      end
      case (state)
        GET_CMD: if (i_Rx_DV) cmd <= i_Rx_Byte;
        GET_ID:  if (i_Rx_DV) id <= i_Rx_Byte;
        GET_CHK: if (i_Rx_DV) begin
          rpt_code <= R_BAD;
          idx <= '0;
          match_hit <= 1'b0;
          free_hit <= 1'b0;
          match_slot <= '0;
          free_slot <= '0;
        end
        SEARCH: begin
          if (valid[idx] && ids[idx] == id && !match_hit) begin
            match_hit <= 1'b1;
            match_slot <= idx;
          end
          if (!valid[idx] && !free_hit) begin
            free_hit <= 1'b1;
            free_slot <= idx;
          end
          idx <= idx + 1'b1;
        end
        DECIDE: begin
          o_Result_DV <= 1'b1;
          o_Result_Id <= id;
          o_Result_Slot <= match_hit ? match_slot : cmd == 8'h01 && free_hit ? free_slot : '0;
          if (cmd == 8'h01) begin
            o_Result <= match_hit ? R_DUP : free_hit ? R_ENR : R_FULL;
            if (!match_hit && free_hit) begin
              ids[free_slot] <= id;
              valid[free_slot] <= 1'b1;
              present[free_slot] <= 1'b0;
              o_Enrolled <= o_Enrolled + 1'b1;
            end
          end else begin
            o_Result <= match_hit ? R_MATCH : R_NOMATCH;
            if (match_hit && !present[match_slot]) begin
              present[match_slot] <= 1'b1;
              o_Attend_Count <= o_Attend_Count + 1'b1;
            end
          end
        end
        CLEAR: begin
          valid <= '0;
          present <= '0;
          o_Enrolled <= '0;
          o_Attend_Count <= '0;
          o_Result_DV <= 1'b1;
          o_Result <= R_CLR;
          o_Result_Id <= id;
          o_Result_Slot <= '0;
        end
        REPORT: begin
          o_Result_DV <= 1'b1;
          o_Result <= rpt_code;
          o_Result_Id <= id;
          o_Result_Slot <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fp_attendance_ctrl.sv
// tb_fp_attendance_ctrl: scoreboard bench for fp_attendance_ctrl with directed frames
module tb_fp_attendance_ctrl;
  localparam int TO = 300;
  localparam logic [2:0] R_ENR = 3'd0, R_MATCH = 3'd1, R_NOMATCH = 3'd2, R_FULL = 3'd3,
                         R_DUP = 3'd4, R_BAD = 3'd5, R_CLR = 3'd6, R_TOUT = 3'd7;
  logic i_Clock = 1'b0;
  logic i_Rst_n = 1'b0;
  logic i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic o_Busy, o_Result_DV;
  logic [2:0] o_Result;
  logic [7:0] o_Result_Id;
  logic [2:0] o_Result_Slot;
  logic [3:0] o_Enrolled, o_Attend_Count;
  fp_attendance_ctrl #(.DEPTH(8), .SOF(8'hA5), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .i_Rx_DV(i_Rx_DV),
    .i_Rx_Byte(i_Rx_Byte),
    .o_Busy(o_Busy),
    .o_Result_DV(o_Result_DV),
    .o_Result(o_Result),
    .o_Result_Id(o_Result_Id),
    .o_Result_Slot(o_Result_Slot),
    .o_Enrolled(o_Enrolled),
    .o_Attend_Count(o_Attend_Count)
  );
  always #5 i_Clock = ~i_Clock;
  typedef struct {
    logic [2:0] code;
    logic [7:0] id;
    logic [2:0] slot;
    logic [3:0] enr;
    logic [3:0] att;
    int due;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;
  always @(negedge i_Clock)
    if (o_Result_DV) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got code=%0d id=%h slot=%0d, required no result",
                 o_Result, o_Result_Id, o_Result_Slot);
      end else begin
        e = q.pop_front();
        if ({o_Result, o_Result_Id, o_Result_Slot, o_Enrolled, o_Attend_Count} !==
            {e.code, e.id, e.slot, e.enr, e.att}) begin
          failures++;
          $display("FAIL result: got code=%0d id=%h slot=%0d enr=%0d att=%0d, required code=%0d id=%h slot=%0d enr=%0d att=%0d",
                   o_Result, o_Result_Id, o_Result_Slot, o_Enrolled, o_Attend_Count,
                   e.code, e.id, e.slot, e.enr, e.att);
        end
        if (e.due != 0) begin
          checks++;
          if (cyc != e.due) begin
            failures++;
            $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, e.due);
          end
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge i_Clock);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                       input logic [2:0] code, input logic [7:0] eid, input logic [2:0] slot,
                       input logic [3:0] enr, input logic [3:0] att, input int lat);
    send(8'hA5);
    send(c);
    send(d);
    @(negedge i_Clock);
    q.push_back('{code, eid, slot, enr, att, cyc + 1 + lat});
    i_Rx_DV = 1'b1;
    i_Rx_Byte = k;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
  endtask
  task automatic wait_done(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge i_Clock);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_result: pending=%0d after %0d cycles, required 0", q.size(), bound);
      q.delete();
    end
    repeat (2) @(negedge i_Clock);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge i_Clock);
    chk("reset_outputs", {o_Busy, o_Result_DV, o_Result, o_Result_Id, o_Result_Slot, o_Enrolled, o_Attend_Count}, 0);
    i_Rst_n = 1'b1;
    @(negedge i_Clock);
    send(8'h33);
    frame(8'h01, 8'h11, 8'h10, R_ENR, 8'h11, 3'd0, 4'd1, 4'd0, 9); wait_done(40);
    frame(8'h01, 8'h11, 8'h10, R_DUP, 8'h11, 3'd0, 4'd1, 4'd0, 9); wait_done(40);
    frame(8'h02, 8'h11, 8'h13, R_MATCH, 8'h11, 3'd0, 4'd1, 4'd1, 9);
    chk("busy_search", o_Busy, 1);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h13);
    wait_done(40);
    repeat (10) @(negedge i_Clock);
    frame(8'h02, 8'h11, 8'h13, R_MATCH, 8'h11, 3'd0, 4'd1, 4'd1, 9); wait_done(40);
    frame(8'h03, 8'h00, 8'h03, R_CLR, 8'h00, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    for (int i = 1; i <= 8; i++) begin
      frame(8'h01, 8'(i), 8'(i) ^ 8'h01, R_ENR, 8'(i), 3'(i - 1), 4'(i), 4'd0, 9);
      wait_done(40);
    end
    frame(8'h01, 8'h09, 8'h08, R_FULL, 8'h09, 3'd0, 4'd8, 4'd0, 9); wait_done(40);
    frame(8'h02, 8'h2A, 8'h28, R_NOMATCH, 8'h2A, 3'd0, 4'd8, 4'd0, 9); wait_done(40);
    frame(8'h02, 8'h05, 8'h07, R_MATCH, 8'h05, 3'd4, 4'd8, 4'd1, 9); wait_done(40);
    frame(8'h03, 8'h00, 8'h03, R_CLR, 8'h00, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h01, 8'h11, 8'hFF, R_BAD, 8'h11, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h07, 8'h00, 8'h07, R_BAD, 8'h00, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h01, 8'h00, 8'h01, R_BAD, 8'h00, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h03, 8'h05, 8'h00, R_BAD, 8'h05, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h03, 8'h05, 8'h06, R_CLR, 8'h05, 3'd0, 4'd0, 4'd0, 1); wait_done(40);
    frame(8'h01, 8'hA5, 8'hA4, R_ENR, 8'hA5, 3'd0, 4'd1, 4'd0, 9); wait_done(40);
    q.push_back('{R_TOUT, 8'h00, 3'd0, 4'd1, 4'd0, 0});
    send(8'hA5);
    send(8'h01);
    wait_done(TO + 50);
    frame(8'h02, 8'hA5, 8'hA7, R_MATCH, 8'hA5, 3'd0, 4'd1, 4'd1, 9); wait_done(40);
    send(8'hA5); send(8'h01); send(8'h22); send(8'h23);
    send(8'hA5);
    chk("busy_before_reset", o_Busy, 1);
    i_Rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_Busy, o_Result_DV, o_Result, o_Result_Id, o_Result_Slot, o_Enrolled, o_Attend_Count}, 0);
    repeat (3) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    repeat (20) @(negedge i_Clock);
    chk("enrolled_after_reset", o_Enrolled, 0);
    frame(8'h02, 8'hA5, 8'hA7, R_NOMATCH, 8'hA5, 3'd0, 4'd0, 4'd0, 9); wait_done(40);
    frame(8'h01, 8'h22, 8'h23, R_ENR, 8'h22, 3'd0, 4'd1, 4'd0, 9); wait_done(40);
    repeat (5) @(negedge i_Clock);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
